// File: rtl/ct_stream_pkg.sv
// Shared types and helpers for the ciphertext stream-out drain stage.
package ct_stream_pkg;

  typedef enum logic [1:0] {
    CS_IDLE   = 2'd0,
    CS_STREAM = 2'd1,
    CS_DRAIN  = 2'd2,
    CS_DONE   = 2'd3
  } ct_stream_state_t;

  // Output FIFO depth: enough to cover a full BRAM round trip plus the
  // registered handshake slot, so a held-ready sink sees no bubbles.
  function automatic int fifo_depth(input int rd_lat);
    return rd_lat + 2;
  endfunction

endpackage

// File: rtl/ct_stream_fifo.sv
// Synchronous show-ahead FIFO: head word is visible on rdata_o whenever
// the FIFO is non-empty. Only pointers and count are reset; storage is not.
module ct_stream_fifo #(
  parameter int WIDTH = 66,
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic [CW-1:0]    count_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam int LAST_I  = DEPTH - 1;
  localparam logic [PW-1:0] LAST_PTR = LAST_I[PW-1:0];
  localparam logic [CW-1:0] DEPTH_C  = DEPTH[CW-1:0];

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == DEPTH_C);
  assign count_o = count_q;
  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // Next pointer and occupancy values.
  always_comb begin
    wr_ptr_d = do_push ? next_ptr(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = do_pop  ? next_ptr(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointer and count registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage write; data path carries no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/ct_stream_out.sv
// Drains ciphertext (c0, c1) from the adder output BRAMs and streams every
// coefficient on a valid/ready master port. BRAM reads are credit-limited so
// the small output FIFO can never overflow under arbitrary backpressure.
module ct_stream_out
  import ct_stream_pkg::*;
#(
  parameter int N      = 8,
  parameter int K      = 2,
  parameter int DATA_W = 64,
  parameter int RD_LAT = 2,
  parameter int AW     = $clog2(N * K)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              c0_en,
  output logic [AW-1:0]     c0_addr,
  input  logic [DATA_W-1:0] c0_dout,
  output logic              c1_en,
  output logic [AW-1:0]     c1_addr,
  input  logic [DATA_W-1:0] c1_dout,
  output logic [DATA_W-1:0] m_tdata,
  output logic              m_tvalid,
  input  logic              m_tready,
  output logic              m_tuser,
  output logic              m_tlast,
  output logic              busy,
  output logic              done
);

  localparam int DEPTH       = fifo_depth(RD_LAT);
  localparam int CW          = $clog2(DEPTH + 1);
  localparam int WIDTH       = DATA_W + 2;
  localparam int ADDR_LAST_I = N * K - 1;
  localparam logic [AW-1:0] ADDR_LAST = ADDR_LAST_I[AW-1:0];
  localparam logic [CW:0]   DEPTH_C   = DEPTH[CW:0];

  ct_stream_state_t state_q, state_d;

  // Global read counter, split as {polynomial select, limb*N+idx}.
  logic          rc_comp_q, rc_comp_d;
  logic [AW-1:0] rc_addr_q, rc_addr_d;

  logic [CW-1:0] out_q, out_d;
  logic [CW:0]   credit_sum;
  logic          issue, last_read;

  logic [RD_LAT-1:0] dl_vld_q, dl_comp_q, dl_last_q;
  logic              ret_vld, ret_comp, ret_last;

  logic [WIDTH-1:0] push_word, head_word;
  logic [CW-1:0]    fifo_count;
  logic             fifo_empty, fifo_full, pop;

  // A read may issue only if every outstanding and queued beat still fits.
  assign credit_sum = {1'b0, out_q} + {1'b0, fifo_count};
  assign issue      = (state_q == CS_STREAM) && (credit_sum < DEPTH_C) && !fifo_full;
  assign last_read  = issue && rc_comp_q && (rc_addr_q == ADDR_LAST);

  assign ret_vld  = dl_vld_q[RD_LAT-1];
  assign ret_comp = dl_comp_q[RD_LAT-1];
  assign ret_last = dl_last_q[RD_LAT-1];

  assign push_word = {ret_last, ret_comp, ret_comp ? c1_dout : c0_dout};

  assign m_tvalid = !fifo_empty;
  assign m_tdata  = head_word[DATA_W-1:0];
  assign m_tuser  = head_word[DATA_W];
  assign m_tlast  = head_word[DATA_W+1];
  assign pop      = m_tvalid && m_tready;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= CS_IDLE;
    else       state_q <= state_d;
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      CS_IDLE:   if (start)             state_d = CS_STREAM;
      CS_STREAM: if (last_read)         state_d = CS_DRAIN;
      CS_DRAIN:  if (pop && m_tlast)    state_d = CS_DONE;
      CS_DONE:   if (!start)            state_d = CS_IDLE;
      default:                          state_d = CS_IDLE;
    endcase
  end

  // FSM outputs: status flags and BRAM read strobes/addresses.
  always_comb begin
    busy    = (state_q == CS_STREAM) || (state_q == CS_DRAIN);
    done    = (state_q == CS_DONE);
    c0_en   = issue && !rc_comp_q;
    c1_en   = issue && rc_comp_q;
    c0_addr = c0_en ? rc_addr_q : '0;
    c1_addr = c1_en ? rc_addr_q : '0;
  end

  // Read counter and outstanding-read credit next values.
  always_comb begin
    rc_addr_d = rc_addr_q;
    rc_comp_d = rc_comp_q;
    if (state_q == CS_IDLE) begin
      rc_addr_d = '0;
      rc_comp_d = 1'b0;
    end else if (issue) begin
      if (rc_addr_q == ADDR_LAST) begin
        rc_addr_d = '0;
        rc_comp_d = 1'b1;
      end else begin
        rc_addr_d = rc_addr_q + 1'b1;
      end
    end
    case ({issue, ret_vld})
      2'b10:   out_d = out_q + 1'b1;
      2'b01:   out_d = out_q - 1'b1;
      default: out_d = out_q;
    endcase
  end

  // Read counter and credit registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      rc_addr_q <= '0;
      rc_comp_q <= 1'b0;
      out_q     <= '0;
    end else begin
      rc_addr_q <= rc_addr_d;
      rc_comp_q <= rc_comp_d;
      out_q     <= out_d;
    end
  end

  // Latency delay line: tags each read so its data is captured RD_LAT later.
  always_ff @(posedge clk) begin
    if (reset) begin
      dl_vld_q  <= '0;
      dl_comp_q <= '0;
      dl_last_q <= '0;
    end else begin
      dl_vld_q[0]  <= issue;
      dl_comp_q[0] <= rc_comp_q;
      dl_last_q[0] <= last_read;
      for (int i = 1; i < RD_LAT; i++) begin
        dl_vld_q[i]  <= dl_vld_q[i-1];
        dl_comp_q[i] <= dl_comp_q[i-1];
        dl_last_q[i] <= dl_last_q[i-1];
      end
    end
  end

  ct_stream_fifo #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .push_i (ret_vld),
    .wdata_i(push_word),
    .pop_i  (pop),
    .rdata_o(head_word),
    .count_o(fifo_count),
    .empty_o(fifo_empty),
    .full_o (fifo_full)
  );

endmodule

// File: tb/tb_ct_stream_out.sv
// Bench for ct_stream_out: BRAM models, ready driver, scoreboard monitor and
// directed scenarios (latency, backpressure, reset mid-run, start handling).
module tb_ct_stream_out;

  localparam int N      = 8;
  localparam int K      = 2;
  localparam int DATA_W = 64;
  localparam int RD_LAT = 2;
  localparam int NK     = N * K;
  localparam int TOTAL  = 2 * NK;
  localparam int AW     = $clog2(NK);
  localparam int DEPTH  = RD_LAT + 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset, start, m_tready;
  logic              c0_en, c1_en, m_tvalid, m_tuser, m_tlast, busy, done;
  logic [AW-1:0]     c0_addr, c1_addr;
  logic [DATA_W-1:0] c0_dout, c1_dout, m_tdata;

  ct_stream_out #(.N(N), .K(K), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .reset(reset), .start(start),
    .c0_en(c0_en), .c0_addr(c0_addr), .c0_dout(c0_dout),
    .c1_en(c1_en), .c1_addr(c1_addr), .c1_dout(c1_dout),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
    .m_tuser(m_tuser), .m_tlast(m_tlast), .busy(busy), .done(done)
  );

  // BRAM contents and RD_LAT-deep read pipelines.
  logic [DATA_W-1:0] mem0 [NK];
  logic [DATA_W-1:0] mem1 [NK];
  logic [DATA_W-1:0] p0 [RD_LAT];
  logic [DATA_W-1:0] p1 [RD_LAT];
  assign c0_dout = p0[RD_LAT-1];
  assign c1_dout = p1[RD_LAT-1];

  always @(posedge clk) begin
    if (c0_en) p0[0] <= mem0[c0_addr];
    if (c1_en) p1[0] <= mem1[c1_addr];
    for (int i = 1; i < RD_LAT; i++) begin
      p0[i] <= p0[i-1];
      p1[i] <= p1[i-1];
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Expected beat i as {last, user, data}.
  function automatic logic [DATA_W+1:0] exp_beat(input int i);
    logic [DATA_W-1:0] d;
    d = (i < NK) ? mem0[i] : mem1[i-NK];
    return {(i == TOTAL - 1), (i >= NK), d};
  endfunction

  // Ready driver: 0 = always high, 1 = 30% high, 2 = always low.
  int rdy_mode = 2;
  initial begin
    m_tready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       m_tready = 1'b1;
        1:       m_tready = ($urandom_range(99) < 30);
        default: m_tready = 1'b0;
      endcase
    end
  end

  logic rst_at_edge;
  always @(posedge clk) rst_at_edge <= reset;

  // Scoreboard monitor.
  int beat_idx = 0, rd_idx = 0, inflight = 0;
  initial begin
    logic              prev_stall, prev_done;
    logic [DATA_W+1:0] prev_word, word;
    prev_stall = 1'b0;
    prev_done  = 1'b0;
    prev_word  = '0;
    @(posedge clk);
    forever begin
      @(negedge clk);
      word = {m_tlast, m_tuser, m_tdata};
      if (rst_at_edge) begin
        chk("reset_ctrl_outputs",
            {c0_en, c1_en, c0_addr, c1_addr, m_tvalid, m_tuser, m_tlast, busy, done}, '0);
        chk("reset_tdata", m_tdata, '0);
        beat_idx = 0; rd_idx = 0; inflight = 0;
        prev_stall = 1'b0; prev_done = 1'b0;
      end else begin
        if (!busy && !done) begin
          beat_idx = 0; rd_idx = 0; inflight = 0;
        end
        chk("en_onehot", c0_en && c1_en, 0);
        chk("busy_done_exclusive", busy && done, 0);
        chk("tvalid_only_when_busy", m_tvalid && !busy, 0);
        if (c0_en || c1_en) begin
          if (rd_idx >= TOTAL) chk("extra_read", rd_idx, TOTAL - 1);
          else chk("rd_sel_addr", {c1_en, (c1_en ? c1_addr : c0_addr)},
                   {(rd_idx >= NK), AW'(rd_idx % NK)});
          rd_idx++;
          inflight++;
          chk("credit_limit", (inflight > DEPTH), 0);
        end
        if (prev_stall) chk("stall_stable", {m_tvalid, word}, {1'b1, prev_word});
        if (m_tvalid && m_tready) begin
          if (beat_idx >= TOTAL) chk("extra_beat", beat_idx, TOTAL - 1);
          else chk($sformatf("beat_%0d", beat_idx), word, exp_beat(beat_idx));
          beat_idx++;
          inflight--;
        end
        if (done && !prev_done) begin
          chk("beats_at_done", beat_idx, TOTAL);
          chk("reads_at_done", rd_idx, TOTAL);
        end
        prev_stall = m_tvalid && !m_tready;
        prev_word  = word;
        prev_done  = done;
      end
    end
  end

  task automatic fill_mem(input bit addr_pattern);
    for (int a = 0; a < NK; a++) begin
      mem0[a] = addr_pattern ? DATA_W'(a) : {$urandom, $urandom};
      mem1[a] = addr_pattern ? DATA_W'(a) : {$urandom, $urandom};
    end
  endtask

  task automatic wait_done(input int budget, input string nm);
    int n = 0;
    while (!done && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_done_reached"}, done, 1);
  endtask

  task automatic wait_beats(input int nb, input int budget, input string nm);
    int n = 0;
    while (beat_idx < nb && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_beats_reached"}, (beat_idx >= nb), 1);
  endtask

  task automatic drop_start_and_idle(input string nm);
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk({nm, "_idle_after_start_low"}, {done, busy}, 2'b00);
  endtask

  initial begin
    int first_v, done_c;
    reset = 1'b1;
    start = 1'b0;
    fill_mem(1'b1);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Address-pattern run, ready held high: latency and literal beats.
    rdy_mode = 0;
    @(posedge clk);
    @(posedge clk); #1 start = 1'b1;
    first_v = -1;
    done_c  = -1;
    for (int cyc = 0; cyc < 200 && done_c < 0; cyc++) begin
      @(negedge clk);
      if (m_tvalid && first_v < 0) first_v = cyc;
      if (done && done_c < 0) done_c = cyc;
      if (cyc == 4)  chk("lit_beat0",  {m_tvalid, m_tlast, m_tuser, m_tdata}, {1'b1, 1'b0, 1'b0, 64'd0});
      if (cyc == 19) chk("lit_beat15", {m_tvalid, m_tlast, m_tuser, m_tdata}, {1'b1, 1'b0, 1'b0, 64'd15});
      if (cyc == 20) chk("lit_beat16", {m_tvalid, m_tlast, m_tuser, m_tdata}, {1'b1, 1'b0, 1'b1, 64'd0});
      if (cyc == 34) chk("lit_beat30", {m_tvalid, m_tlast, m_tuser, m_tdata}, {1'b1, 1'b0, 1'b1, 64'd14});
      if (cyc == 35) chk("lit_beat31", {m_tvalid, m_tlast, m_tuser, m_tdata}, {1'b1, 1'b1, 1'b1, 64'd15});
    end
    chk("first_tvalid_cycle", first_v, 4);
    chk("done_cycle", done_c, 36);
    drop_start_and_idle("t1");

    // Random data, random 30% ready.
    rdy_mode = 1;
    for (int r = 0; r < 2; r++) begin
      fill_mem(1'b0);
      @(posedge clk); #1 start = 1'b1;
      wait_done(3000, "t2");
      drop_start_and_idle("t2");
    end

    // Ready low for 100 cycles: credit stops reads at DEPTH.
    fill_mem(1'b0);
    rdy_mode = 2;
    @(posedge clk); #1 start = 1'b1;
    repeat (100) @(negedge clk);
    chk("stalled_reads", rd_idx, DEPTH);
    chk("stalled_no_beats", beat_idx, 0);
    chk("stalled_en_low", {c0_en, c1_en, busy}, 3'b001);
    rdy_mode = 0;
    wait_done(500, "t3");
    drop_start_and_idle("t3");

    // Reset in the middle of the stream, then a fresh run.
    fill_mem(1'b0);
    rdy_mode = 0;
    @(posedge clk); #1 start = 1'b1;
    wait_beats(10, 200, "t4");
    @(posedge clk); #1 begin reset = 1'b1; start = 1'b0; end
    @(posedge clk); #1 reset = 1'b0;
    repeat (10) @(negedge clk);
    chk("after_reset_quiet", {m_tvalid, busy, done}, 3'b000);
    rdy_mode = 1;
    @(posedge clk); #1 start = 1'b1;
    wait_done(3000, "t4b");
    drop_start_and_idle("t4b");

    // Start dropped mid-stream: done lasts one cycle.
    fill_mem(1'b0);
    rdy_mode = 0;
    @(posedge clk); #1 start = 1'b1;
    wait_beats(5, 200, "t5");
    @(posedge clk); #1 start = 1'b0;
    wait_done(500, "t5");
    @(negedge clk);
    chk("t5_done_one_cycle", {done, busy}, 2'b00);

    // Start held through completion: done held, no second stream.
    @(posedge clk); #1 start = 1'b1;
    wait_done(500, "t6");
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("t6_done_held", {done, busy, c0_en, c1_en}, 4'b1000);
    end
    drop_start_and_idle("t6");

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
